// File: rtl/sdram_burst_rw.sv
// rtl/sdram_burst_rw.sv - splits byte requests into auto-precharged halfword SDRAM accesses
// Optional periodic AUTO REFRESH is built in when SDRAM_AUTO_REFRESH_EN is defined.
`timescale 1ns/100ps
module sdram_burst_rw #(
  parameter int NBYTES     = 8,
  parameter int CAS_LAT    = 2,
  parameter int T_RCD      = 3,
  parameter int T_REC      = 3,
  parameter int REF_PERIOD = 1560,
  parameter int T_RFC      = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd_enable,
  input  logic                  wr_enable,
  input  logic [25:0]           addr,
  input  logic [8*NBYTES-1:0]   wr_data,
  output logic [8*NBYTES-1:0]   rd_data,
  output logic                  busy,
  output logic                  end_op,
  output logic [12:0]           dram_addr,
  output logic [1:0]            dram_ba,
  output logic                  dram_cs_n,
  output logic                  dram_ras_n,
  output logic                  dram_cas_n,
  output logic                  dram_we_n,
  output logic                  dram_ldqm,
  output logic                  dram_udqm,
  inout  wire  [15:0]           dram_dq
);
  localparam int NW = $clog2(NBYTES/2 + 2);
  localparam int PW = 8*(NBYTES + 2);
  // One counter width covers every interval this block times.
  localparam int CW = $clog2(REF_PERIOD + T_RFC + T_RCD + T_REC + 1);

  typedef enum logic [2:0] {IDLE, ACT, RCD_WAIT, CMD, REC_WAIT, REF, RFC_WAIT} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [NW-1:0] idx;
  logic [24:0]   hw;
  logic          a0, rd_a0, is_read;
  logic [PW-1:0] wr_pad, rd_pad;
  logic [3:0]    cmd;
  logic [1:0]    dqm, acc_dqm;
  logic          dq_oe, refresh_due, accept, last_acc, rec_done;

  // Byte-wide padding lets an odd start address map lane bytes without negative indices.
  assign last_acc = (idx == NW'(NBYTES/2 - 1) + NW'(a0));
  assign rec_done = (cnt == CW'(T_REC - 1));
  assign accept   = (state == IDLE) && !refresh_due && (rd_enable || wr_enable);
  assign busy     = (state != IDLE) || refresh_due;
  assign acc_dqm  = (a0 && idx == '0) ? 2'b01 : (a0 && last_acc) ? 2'b10 : 2'b00;
  assign rd_data  = rd_a0 ? rd_pad[8 +: 8*NBYTES] : rd_pad[0 +: 8*NBYTES];
  assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd;
  assign {dram_udqm, dram_ldqm} = dqm;
  assign dram_dq = dq_oe ? wr_pad[16*idx +: 16] : 16'hzzzz;

`ifdef SDRAM_AUTO_REFRESH_EN
  logic [CW-1:0] ref_cnt;
  logic          ref_pending, ref_expire;

  assign ref_expire  = (ref_cnt == CW'(REF_PERIOD - 1));
  // An expiry in the same cycle as a request already blocks it.
  assign refresh_due = ref_pending || ref_expire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      ref_cnt <= ref_expire ? '0 : ref_cnt + 1'b1;
      if (ref_expire)
        ref_pending <= 1'b1;
      else if (state == RFC_WAIT && cnt == CW'(T_RFC - 1))
        ref_pending <= 1'b0;
    end
  end
`else
  assign refresh_due = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    cmd       = 4'b0111;
    dram_addr = '0;
    dram_ba   = '0;
    dqm       = 2'b11;
    dq_oe     = 1'b0;
    case (state)
      IDLE:     if (refresh_due) state_nx = REF;
                else if (accept) state_nx = ACT;
      ACT: begin
        cmd       = 4'b0011;
        dram_addr = hw[22:10];
        dram_ba   = hw[24:23];
        dqm       = acc_dqm;
        state_nx  = RCD_WAIT;
      end
      RCD_WAIT: if (cnt == CW'(T_RCD - 1)) state_nx = CMD;
      CMD: begin
        cmd       = is_read ? 4'b0101 : 4'b0100;
        dram_addr = {2'b00, 1'b1, hw[9:0]};
        dram_ba   = hw[24:23];
        dqm       = acc_dqm;
        dq_oe     = !is_read;
        state_nx  = REC_WAIT;
      end
      REC_WAIT: if (rec_done) state_nx = last_acc ? IDLE : ACT;
      REF: begin
        cmd      = 4'b0001;
        state_nx = RFC_WAIT;
      end
      RFC_WAIT: if (cnt == CW'(T_RFC - 1)) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      hw      <= '0;
      a0      <= 1'b0;
      rd_a0   <= 1'b0;
      is_read <= 1'b0;
      wr_pad  <= '0;
      rd_pad  <= '0;
      end_op  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= (state_nx != state) ? '0 : cnt + 1'b1;
      end_op <= (state == REC_WAIT) && rec_done && last_acc;
      if (accept) begin
        hw      <= addr[25:1];
        a0      <= addr[0];
        is_read <= rd_enable;
        idx     <= '0;
        wr_pad  <= addr[0] ? {8'h00, wr_data, 8'h00} : {16'h0000, wr_data};
        if (rd_enable) rd_a0 <= addr[0];
      end
      // Data arrives CAS_LAT edges after the edge that registered READ.
      if (state == REC_WAIT && is_read && cnt == CW'(CAS_LAT - 1)) begin
        if (!acc_dqm[0]) rd_pad[16*idx +: 8]     <= dram_dq[7:0];
        if (!acc_dqm[1]) rd_pad[16*idx + 8 +: 8] <= dram_dq[15:8];
      end
      if (state == REC_WAIT && rec_done) begin
        hw  <= hw + 1'b1;
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: doc/sdram_burst_rw.md
SDRAM_BURST_RW -- requirements
Module: sdram_burst_rw

Interface
REQ-001 SHALL have parameter NBYTES, default 8, bytes per request (even, 2..16).
REQ-002 SHALL have parameter CAS_LAT, default 2, read CAS latency in clocks (2 or 3).
REQ-003 SHALL have parameter T_RCD, default 3, NOP cycles between ACTIVE and READ/WRITE.
REQ-004 SHALL have parameter T_REC, default 3, NOP cycles after READ/WRITE before the next ACTIVE (>= CAS_LAT).
REQ-005 SHALL have parameter REF_PERIOD, default 1560, clocks between refresh requests.
REQ-006 SHALL have parameter T_RFC, default 13, NOP cycles after AUTO REFRESH.
REQ-007 SHALL have ports, in this order:
- clock  in  1  rising-edge clock (200 MHz).
- reset  in  1  reset, asynchronous, active-high.
- rd_enable  in  1  read request.
- wr_enable  in  1  write request.
- addr  in  26  byte address {bank[1:0], row[12:0], column[9:0], lane}.
- wr_data  in  8*NBYTES  write data; byte k targets addr+k.
- rd_data  out  8*NBYTES  read data; byte k from addr+k.
- busy  out  1  high while not accepting requests.
- end_op  out  1  one-cycle completion pulse.
- dram_addr  out  13; dram_ba  out  2; dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n  out  1 each; dram_ldqm, dram_udqm  out  1 each; dram_dq  inout  16.

Function
REQ-008 SHALL accept a request on a rising edge where busy=0 and rd_enable or wr_enable is 1, latching addr and wr_data; rd_enable=wr_enable=1 SHALL perform a read.
REQ-009 SHALL ignore rd_enable/wr_enable while busy=1.
REQ-010 SHALL split a request into halfword accesses: NBYTES/2 if addr[0]=0, NBYTES/2+1 if addr[0]=1.
REQ-011 For addr[0]=1, the first access SHALL drive {udqm,ldqm}=01 and the last SHALL drive 10; all other accesses SHALL drive 00.
REQ-012 Halfword address SHALL increment by 1 per access, carrying column->row->bank; 26-bit wrap from all-ones to 0 SHALL be silent.
REQ-013 Each access SHALL be: ACTIVE (0011, row, bank), T_RCD NOPs, READ (0101) or WRITE (0100) with dram_addr[10]=1 (auto precharge), dram_addr[9:0]=column, then T_REC NOPs.
REQ-014 Commands SHALL be {cs_n,ras_n,cas_n,we_n}; NOP=0111, AUTO REFRESH=0001.
REQ-015 dram_dq SHALL be driven only in the WRITE command cycle, else high-Z.
REQ-016 Read data SHALL be sampled on the CAS_LAT-th rising edge after the READ edge; only unmasked lanes update rd_data.
REQ-017 FSM states SHALL be IDLE, ACT, RCD_WAIT, CMD, REC_WAIT, REF, RFC_WAIT; after REC_WAIT of the last access it SHALL return to IDLE, pulsing end_op for one cycle.
REQ-018 rd_data SHALL be stable from the end_op cycle until the next read is accepted.
REQ-019 busy SHALL be 1 in every state except IDLE, and 1 in IDLE while a refresh is pending.
REQ-020 Outside ACT/CMD, dram_addr and dram_ba SHALL be 0 and dqm SHALL be 11.

Reset
REQ-021 On reset: state IDLE, busy=0, end_op=0, rd_data=0, command NOP, dram_addr=0, dram_ba=0, dqm=11, dram_dq high-Z, refresh counter 0, pending flag cleared.
REQ-022 Reset mid-operation SHALL abort immediately, with no end_op pulse.

Configuration
REQ-023 With SDRAM_AUTO_REFRESH_EN defined: a free-running counter SHALL set a pending flag every REF_PERIOD clocks. In IDLE, pending SHALL take priority over new requests and SHALL issue AUTO REFRESH, then T_RFC NOPs, clear pending, and return to IDLE. A second expiry while pending SHALL NOT queue.
REQ-024 Without the macro: no refresh logic, REF/RFC_WAIT unreachable, busy=0 in IDLE.

Verification (NBYTES=8, CAS_LAT=2, T_RCD=3, T_REC=3)
REQ-025 Write addr=0x0000100, wr_data=0x8877665544332211 -> 4 accesses, columns 0x080..0x083, dq=0x2211,0x4433,0x6655,0x8877, dqm 00; end_op 32 cycles after accept.
REQ-026 Read addr=0x0000101 -> 5 accesses, dqm 01,00,00,00,10; rd_data holds bytes 0x101..0x108.
REQ-027 Read from column 0x3FF, row 5 -> second access ACTIVE row 6, column 0x000.
REQ-028 rd_enable=wr_enable=1 -> READ commands only; dq never driven.
REQ-029 Assert reset during RCD_WAIT of access 2 -> next edge shows NOP, dqm=11, busy=0, no end_op.
REQ-030 (SDRAM_AUTO_REFRESH_EN) Counter expiry with a request arriving the same cycle -> AUTO REFRESH first, 13 NOPs, then the request may be accepted.
